hs_npu_cmd_sequencer: RTL and testbench

Upstream command front-end for the NPU top level. It accepts layer descriptors over a valid/ready stream and drives the NPU CSR AXI4-Lite slave, writing one register per descriptor word, with start in the last word. It then waits for the NPU completion interrupt, reads the status CSR, acknowledges the interrupt, and returns a completion record. This lets a host or DMA queue back-to-back layers without CPU polling.

---
 rtl/hs_npu_pkg.sv | 22 ++
 rtl/hs_npu_axil_write_beat.sv | 66 ++++++
 rtl/hs_npu_cmd_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_hs_npu_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_npu_pkg.sv
// rtl/hs_npu_pkg.sv - shared state/error types for the NPU command sequencer
package hs_npu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    WAIT_IRQ,
    RD,
    ACK,
    DONE
  } cmd_state_e;

  typedef enum logic [1:0] {
    CMD_OK      = 2'd0,
    CMD_SLVERR  = 2'd1,
    CMD_TIMEOUT = 2'd2
  } cmd_err_e;

  localparam logic [1:0] AXIL_RESP_OKAY = 2'b00;

endpackage

// File: rtl/hs_npu_axil_write_beat.sv
// rtl/hs_npu_axil_write_beat.sv - one AXI-Lite AW+W beat with independent handshakes and B capture
module hs_npu_axil_write_beat
  import hs_npu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  output logic        bwait_o,
  output logic        bfire_o,
  output logic        berr_o
);

  logic        awvalid_q, wvalid_q, bready_q;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_clear, w_clear;

  // A channel counts as finished if it already handshook or handshakes this cycle.
  assign aw_clear = !awvalid_q || awready_i;
  assign w_clear  = !wvalid_q || wready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (start_i) begin
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
      awaddr_q  <= addr_i;
      wdata_q   <= data_i;
      wstrb_q   <= 4'hF;
    end else begin
      if (awvalid_q && awready_i) awvalid_q <= 1'b0;
      if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
      if ((awvalid_q || wvalid_q) && aw_clear && w_clear) bready_q <= 1'b1;
      else if (bready_q && bvalid_i)                        bready_q <= 1'b0;
    end
  end

  assign awvalid_o = awvalid_q;
  assign awaddr_o  = awaddr_q;
  assign wvalid_o  = wvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign bready_o  = bready_q;
  assign bwait_o   = bready_q;
  assign bfire_o   = bready_q && bvalid_i;
  assign berr_o    = (bresp_i != AXIL_RESP_OKAY);

endmodule

// File: rtl/hs_npu_cmd_sequencer.sv
// rtl/hs_npu_cmd_sequencer.sv - layer descriptor to NPU CSR sequencer; irq watchdog under HS_NPU_CMD_TIMEOUT_EN
module hs_npu_cmd_sequencer
  import hs_npu_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 8,
  parameter logic [31:0] CSR_BASE       = 32'h0,
  parameter logic [31:0] STATUS_OFFSET  = 32'h20,
  parameter logic [31:0] IRQ_ACK_OFFSET = 32'h24,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [32*NUM_REGS-1:0] desc_data,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [31:0]           done_status,
  output logic [1:0]            done_err,
  input  logic                  irq_npu,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_awaddr,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [31:0]           m_araddr,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  busy
);

  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REGS - 1);

  cmd_state_e                   state_q;
  cmd_err_e                     err_q;
  logic [IDXW-1:0]              idx_q, idx_d;
  logic [NUM_REGS-1:0][31:0]    desc_q;
  logic [31:0]                  done_status_q, araddr_q;
  logic                         done_valid_q, desc_ready_q, busy_q, arvalid_q, rready_q;
`ifdef HS_NPU_CMD_TIMEOUT_EN
  logic [31:0]                  wait_cnt_q;
`endif

  logic        accept, advance, rd_done, beat_start;
  logic        bwait, bfire, berr;
  logic [31:0] beat_addr, beat_data;

  assign accept     = (state_q == IDLE) && desc_valid && desc_ready_q;
  assign advance    = ((state_q == WR) || (state_q == WRESP)) && bfire && !berr && (idx_q != LAST_IDX);
  assign rd_done    = (state_q == RD) && rready_q && m_rvalid;
  assign beat_start = accept || advance || rd_done;
  assign idx_d      = accept ? '0 : idx_q + IDXW'(1);

  // The beat is launched in the same cycle as the decision, so its address/data come from next-state values.
  always_comb begin
    beat_addr = CSR_BASE + (32'(idx_d) << 2);
    beat_data = accept ? desc_data[31:0] : desc_q[idx_d];
    if (rd_done) begin
      beat_addr = CSR_BASE + IRQ_ACK_OFFSET;
      beat_data = 32'h1;
    end
  end

  hs_npu_axil_write_beat u_write_beat (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (beat_start),
    .addr_i    (beat_addr),
    .data_i    (beat_data),
    .awvalid_o (m_awvalid),
    .awready_i (m_awready),
    .awaddr_o  (m_awaddr),
    .wvalid_o  (m_wvalid),
    .wready_i  (m_wready),
    .wdata_o   (m_wdata),
    .wstrb_o   (m_wstrb),
    .bvalid_i  (m_bvalid),
    .bready_o  (m_bready),
    .bresp_i   (m_bresp),
    .bwait_o   (bwait),
    .bfire_o   (bfire),
    .berr_o    (berr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      err_q         <= CMD_OK;
      idx_q         <= '0;
      desc_q        <= '0;
      done_status_q <= '0;
      done_valid_q  <= 1'b0;
      desc_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      araddr_q      <= '0;
`ifdef HS_NPU_CMD_TIMEOUT_EN
      wait_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            desc_q        <= desc_data;
            idx_q         <= '0;
            err_q         <= CMD_OK;
            done_status_q <= '0;
            desc_ready_q  <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= WR;
          end else begin
            desc_ready_q  <= 1'b1;
          end
        end
        WR, WRESP: begin
          if (bfire) begin
            if (berr) begin
              err_q        <= CMD_SLVERR;
              done_valid_q <= 1'b1;
              state_q      <= DONE;
            end else if (idx_q == LAST_IDX) begin
              state_q      <= WAIT_IRQ;
`ifdef HS_NPU_CMD_TIMEOUT_EN
              wait_cnt_q   <= '0;
`endif
            end else begin
              idx_q        <= idx_d;
              state_q      <= WR;
            end
          end else if (bwait) begin
            state_q <= WRESP;
          end
        end
        WAIT_IRQ: begin
          if (irq_npu) begin
            arvalid_q <= 1'b1;
            araddr_q  <= CSR_BASE + STATUS_OFFSET;
            state_q   <= RD;
          end
`ifdef HS_NPU_CMD_TIMEOUT_EN
          else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            err_q         <= CMD_TIMEOUT;
            done_status_q <= 32'hFFFF_FFFF;
            done_valid_q  <= 1'b1;
            state_q       <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
`endif
        end
        RD: begin
          if (arvalid_q && m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
          // A bad read response is reported but the irq is still acknowledged.
          if (rd_done) begin
            rready_q      <= 1'b0;
            done_status_q <= m_rdata;
            if (m_rresp != AXIL_RESP_OKAY) err_q <= CMD_SLVERR;
            state_q       <= ACK;
          end
        end
        ACK: begin
          if (bfire) begin
            if (berr) err_q <= CMD_SLVERR;
            done_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid_q <= 1'b0;
            desc_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign desc_ready  = desc_ready_q;
  assign done_valid  = done_valid_q;
  assign done_status = done_status_q;
  assign done_err    = err_q;
  assign m_arvalid   = arvalid_q;
  assign m_araddr    = araddr_q;
  assign m_rready    = rready_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_hs_npu_cmd_sequencer.sv
// tb/tb_hs_npu_cmd_sequencer.sv - directed scoreboard bench with an AXI-Lite slave model for hs_npu_cmd_sequencer
module tb_hs_npu_cmd_sequencer;

  localparam int          NR        = 8;
  localparam int          TMO       = 50;
  localparam logic [31:0] ACK_ADDR  = 32'h24;
  localparam logic [31:0] STAT_ADDR = 32'h20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            desc_valid = 1'b0;
  logic            desc_ready;
  logic [32*NR-1:0] desc_data = '0;
  logic            done_valid;
  logic            done_ready = 1'b0;
  logic [31:0]     done_status;
  logic [1:0]      done_err;
  logic            irq_npu = 1'b0;
  logic            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy;
  logic            m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
  logic [31:0]     m_awaddr, m_wdata, m_araddr;
  logic [3:0]      m_wstrb;
  logic [1:0]      m_bresp = 2'b00, m_rresp = 2'b00;
  logic [31:0]     m_rdata = 32'h0;

  hs_npu_cmd_sequencer #(
    .NUM_REGS(NR), .CSR_BASE(32'h0), .STATUS_OFFSET(32'h20),
    .IRQ_ACK_OFFSET(32'h24), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .done_valid(done_valid), .done_ready(done_ready), .done_status(done_status), .done_err(done_err),
    .irq_npu(irq_npu),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .busy(busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [63:0] exp_wr_q[$];
  logic [33:0] exp_done_q[$];

  int          aw_dly = 0, w_dly = 0, b_dly = 0, irq_dly = 5, err_word = 0;
  bit          err_en = 0, irq_auto = 1;
  logic [31:0] status_val = 32'h1;
  logic [1:0]  rresp_val = 2'b00;

  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, irq_cnt = -1, wr_idx = 0;
  bit          got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0, irq_level = 0;
  logic [31:0] aw_addr_l, w_data_l;
  logic [3:0]  w_strb_l;
  logic [1:0]  b_resp_l = 2'b00;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0;
  int          cyc = 0, last_b_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Slave model bookkeeping: handshakes are sampled at posedge before the DUT updates.
  always @(posedge clk) begin
    logic [63:0] e;
    cyc++;
    if (!rst_n) begin
      got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; irq_cnt = -1; irq_level = 0;
    end else begin
      if (irq_cnt > 0) irq_cnt--;
      else if (irq_cnt == 0) begin irq_level = 1; irq_cnt = -1; end
      if (m_awvalid && m_awready) begin
        chk("one_outstanding", {62'h0, b_pend, r_pend}, 64'h0);
        got_aw = 1; aw_addr_l = m_awaddr; n_aw++; aw_cnt = 0;
      end else if (m_awvalid) aw_cnt++;
      if (m_wvalid && m_wready) begin
        got_w = 1; w_data_l = m_wdata; w_strb_l = m_wstrb; n_w++; w_cnt = 0;
      end else if (m_wvalid) w_cnt++;
      if (m_bvalid && m_bready) begin
        n_b++; b_pend = 0; last_b_cyc = cyc;
        if (wr_idx == NR && aw_addr_l != ACK_ADDR && irq_auto) irq_cnt = irq_dly;
      end else if (b_pend) b_cnt++;
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
        if (exp_wr_q.size() == 0) chk("wr_extra_beat", {aw_addr_l, w_data_l}, 64'hDEAD_DEAD_DEAD_DEAD);
        else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", aw_addr_l, e[63:32]);
          chk("wr_data", w_data_l, e[31:0]);
        end
        chk("wr_strb", w_strb_l, 4'hF);
        b_resp_l = (err_en && aw_addr_l != ACK_ADDR && wr_idx == err_word) ? 2'b10 : 2'b00;
        if (aw_addr_l == ACK_ADDR) irq_level = 0;
        else wr_idx++;
      end
      if (m_arvalid && m_arready) begin
        n_ar++; chk("araddr", m_araddr, STAT_ADDR); r_pend = 1;
      end
      if (m_rvalid && m_rready) r_pend = 0;
    end
  end

  always @(negedge clk) begin
    m_awready = m_awvalid && (aw_cnt >= aw_dly);
    m_wready  = m_wvalid && (w_cnt >= w_dly);
    m_bvalid  = b_pend && (b_cnt >= b_dly);
    m_bresp   = m_bvalid ? b_resp_l : 2'b00;
    m_arready = m_arvalid;
    m_rvalid  = r_pend;
    m_rdata   = r_pend ? status_val : 32'h0;
    m_rresp   = r_pend ? rresp_val : 2'b00;
    irq_npu   = irq_level;
  end

  task automatic send_desc(input logic [31:0] base, input int n_words, input bit exp_ack,
                           input logic [31:0] exp_status, input logic [1:0] exp_err);
    bit ok;
    for (int i = 0; i < NR; i++) desc_data[32*i +: 32] = base + 32'(i);
    for (int i = 0; i < n_words; i++) exp_wr_q.push_back({32'(4 * i), base + 32'(i)});
    if (exp_ack) exp_wr_q.push_back({ACK_ADDR, 32'h1});
    exp_done_q.push_back({exp_err, exp_status});
    wr_idx = 0;
    desc_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (desc_ready) begin ok = 1; break; end
    end
    if (!ok) chk("desc_accept_timeout", {63'h0, desc_ready}, 64'h1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    chk("desc_ready_drop", {63'h0, desc_ready}, 64'h0);
    chk("busy_after_accept", {63'h0, busy}, 64'h1);
  endtask

  task automatic wait_done(input int budget, input bit consume, output int seen_cyc);
    bit seen;
    logic [33:0] e;
    seen = 0; seen_cyc = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_valid) begin seen = 1; seen_cyc = cyc; break; end
    end
    if (exp_done_q.size() != 0) e = exp_done_q.pop_front();
    else e = '0;
    if (!seen) chk("done_timeout", {63'h0, done_valid}, 64'h1);
    else begin
      chk("done_status", done_status, e[31:0]);
      chk("done_err", {62'h0, done_err}, {62'h0, e[33:32]});
      chk("wr_all_seen", 64'(exp_wr_q.size()), 64'h0);
    end
    if (consume) begin
      done_ready = 1'b1;
      @(posedge clk); #1;
      done_ready = 1'b0;
      chk("done_valid_drop", {63'h0, done_valid}, 64'h0);
      chk("desc_ready_back", {63'h0, desc_ready}, 64'h1);
      chk("busy_idle", {63'h0, busy}, 64'h0);
    end
  endtask

  initial begin
    int aw0, w0, b0, ar0, sc;
    bit ok;
    logic [31:0] hold_status;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_desc_ready", {63'h0, desc_ready}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done_valid", {63'h0, done_valid}, 64'h0);
    chk("rst_awvalid", {63'h0, m_awvalid}, 64'h0);
    chk("rst_arvalid", {63'h0, m_arvalid}, 64'h0);
    chk("rst_done_err", {62'h0, done_err}, 64'h0);
    chk("rst_awaddr", m_awaddr, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_desc_ready", {63'h0, desc_ready}, 64'h1);

    // Basic layer
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar;
    send_desc(32'h100, NR, 1, 32'h1, 2'd0);
    wait_done(500, 1, sc);
    chk("t1_aw_count", 64'(n_aw - aw0), 64'd9);
    chk("t1_w_count", 64'(n_w - w0), 64'd9);
    chk("t1_b_count", 64'(n_b - b0), 64'd9);
    chk("t1_ar_count", 64'(n_ar - ar0), 64'd1);

    // Skewed AW/W readiness
    aw_dly = 3; w_dly = 0; status_val = 32'hA5A5_0002;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    send_desc(32'h200, NR, 1, 32'hA5A5_0002, 2'd0);
    wait_done(1000, 1, sc);
    chk("t2a_aw_count", 64'(n_aw - aw0), 64'd9);
    chk("t2a_w_count", 64'(n_w - w0), 64'd9);
    chk("t2a_b_count", 64'(n_b - b0), 64'd9);
    aw_dly = 0; w_dly = 3; b_dly = 2; status_val = 32'h0000_0BEE;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    send_desc(32'h300, NR, 1, 32'h0000_0BEE, 2'd0);
    wait_done(1000, 1, sc);
    chk("t2b_aw_count", 64'(n_aw - aw0), 64'd9);
    chk("t2b_w_count", 64'(n_w - w0), 64'd9);
    chk("t2b_b_count", 64'(n_b - b0), 64'd9);
    w_dly = 0; b_dly = 0;

    // Read response error still acknowledges the irq
    rresp_val = 2'b10; status_val = 32'h55;
    send_desc(32'h380, NR, 1, 32'h55, 2'd1);
    wait_done(500, 1, sc);
    rresp_val = 2'b00;

    // Write error on word 3
    err_en = 1; err_word = 3;
    aw0 = n_aw; ar0 = n_ar;
    send_desc(32'h400, 4, 0, 32'h0, 2'd1);
    wait_done(500, 1, sc);
    chk("t3_aw_count", 64'(n_aw - aw0), 64'd4);
    chk("t3_ar_count", 64'(n_ar - ar0), 64'd0);
    err_en = 0;

    // Completion backpressure with a descriptor waiting
    status_val = 32'h0000_1234;
    send_desc(32'h500, NR, 1, 32'h0000_1234, 2'd0);
    wait_done(500, 0, sc);
    hold_status = 32'h0000_1234;
    for (int i = 0; i < NR; i++) desc_data[32*i +: 32] = 32'h600 + 32'(i);
    for (int i = 0; i < NR; i++) exp_wr_q.push_back({32'(4 * i), 32'h600 + 32'(i)});
    exp_wr_q.push_back({ACK_ADDR, 32'h1});
    exp_done_q.push_back({2'd0, 32'h0000_1234});
    desc_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_desc_ready_low", {63'h0, desc_ready}, 64'h0);
      chk("t4_done_valid_hold", {63'h0, done_valid}, 64'h1);
      chk("t4_status_hold", done_status, hold_status);
      chk("t4_err_hold", {62'h0, done_err}, 64'h0);
    end
    wr_idx = 0;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("t4_done_valid_drop", {63'h0, done_valid}, 64'h0);
    chk("t4_desc_ready_next", {63'h0, desc_ready}, 64'h1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    chk("t4_accepted", {63'h0, busy}, 64'h1);
    wait_done(500, 1, sc);

    // Reset while a B is being offered
    b_dly = 3;
    send_desc(32'h700, NR, 1, 32'h0, 2'd0);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (m_bvalid && m_bready) begin ok = 1; break; end
    end
    if (!ok) chk("t5_bvalid_timeout", {63'h0, m_bvalid}, 64'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_desc_ready", {63'h0, desc_ready}, 64'h0);
    chk("t5_busy", {63'h0, busy}, 64'h0);
    chk("t5_awvalid", {63'h0, m_awvalid}, 64'h0);
    chk("t5_wvalid", {63'h0, m_wvalid}, 64'h0);
    chk("t5_bready", {63'h0, m_bready}, 64'h0);
    chk("t5_done_valid", {63'h0, done_valid}, 64'h0);
    chk("t5_awaddr", m_awaddr, 64'h0);
    rst_n = 1'b1;
    exp_wr_q.delete();
    exp_done_q.delete();
    b_dly = 0; status_val = 32'h0000_0077;
    @(posedge clk); #1;
    chk("t5_desc_ready_after", {63'h0, desc_ready}, 64'h1);
    aw0 = n_aw;
    send_desc(32'h800, NR, 1, 32'h0000_0077, 2'd0);
    wait_done(500, 1, sc);
    chk("t5_aw_count", 64'(n_aw - aw0), 64'd9);

`ifdef HS_NPU_CMD_TIMEOUT_EN
    irq_auto = 0;
    aw0 = n_aw; ar0 = n_ar;
    send_desc(32'h900, NR, 0, 32'hFFFF_FFFF, 2'd2);
    wait_done(500, 1, sc);
    chk("t6_timeout_latency", 64'(sc - last_b_cyc), 64'd50);
    chk("t6_aw_count", 64'(n_aw - aw0), 64'd8);
    chk("t6_ar_count", 64'(n_ar - ar0), 64'd0);
    irq_auto = 1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
